// File: rtl/ps2_key_decoder_if.sv
// PS/2 keyboard lines plus the decoded user-command outputs of ps2_key_decoder.
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] usr_op;
  logic       op_valid;
  logic       frame_err;

  modport master (output ps2_clk, ps2_data, input usr_op, op_valid, frame_err);
  modport slave  (input ps2_clk, ps2_data, output usr_op, op_valid, frame_err);
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code-set-2 receiver that turns key presses into one-cycle user op codes.
// Optional REPEAT_FILTER_EN suppresses typematic repeats until the key's break code.
module ps2_key_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic           clk,
  input  logic           rst,
  ps2_key_decoder_if.slave ps2
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;

  function automatic logic [3:0] map_normal(input logic [7:0] code);
    case (code)
      8'h1D:   return 4'd1;
      8'h1B:   return 4'd2;
      8'h1C:   return 4'd3;
      8'h23:   return 4'd4;
      8'h29:   return 4'd5;
      8'h5A:   return 4'd6;
      8'h31:   return 4'd7;
      8'h55:   return 4'd8;
      8'h4E:   return 4'd9;
      8'h21:   return 4'd10;
      8'h2D:   return 4'd11;
      8'h3A:   return 4'd12;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] map_ext(input logic [7:0] code);
    case (code)
      8'h75:   return 4'd1;
      8'h72:   return 4'd2;
      8'h6B:   return 4'd3;
      8'h74:   return 4'd4;
      8'h5A:   return 4'd6;
      default: return 4'd0;
    endcase
  endfunction

  logic [1:0]     clk_sync_q, clk_sync_d;
  logic [1:0]     data_sync_q, data_sync_d;
  logic           filt_clk_q, filt_clk_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           parity_q, parity_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           byte_valid_q, byte_valid_d;
  logic           frame_err_q, frame_err_d;
  logic [3:0]     usr_op_q, usr_op_d;
  logic           op_valid_q, op_valid_d;
  state_t         state_q, state_d;
  logic           fall_edge;
  logic [3:0]     make_op;
`ifdef REPEAT_FILTER_EN
  logic [12:0]    held_q, held_d;
  logic [3:0]     brk_op;
`endif

  always_comb begin
    clk_sync_d   = {clk_sync_q[0], ps2.ps2_clk};
    data_sync_d  = {data_sync_q[0], ps2.ps2_data};
    filt_clk_d   = filt_clk_q;
    filt_cnt_d   = '0;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    to_cnt_d     = to_cnt_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    usr_op_d     = 4'd0;
    state_d      = state_q;
    fall_edge    = 1'b0;
    make_op      = 4'd0;
`ifdef REPEAT_FILTER_EN
    held_d       = held_q;
    brk_op       = 4'd0;
`endif

    // A level change is accepted only once it has persisted for FILTER_LEN samples.
    if (clk_sync_q[1] != filt_clk_q) begin
      if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_clk_d = clk_sync_q[1];
        fall_edge  = filt_clk_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end

    if (fall_edge) begin
      to_cnt_d = '0;
      case (bit_cnt_q)
        4'd0: if (!data_sync_q[1]) bit_cnt_d = 4'd1;
        4'd9: begin
          parity_d  = data_sync_q[1];
          bit_cnt_d = 4'd10;
        end
        4'd10: begin
          bit_cnt_d = 4'd0;
          if (data_sync_q[1] && (^{parity_q, shift_q})) byte_valid_d = 1'b1;
          else frame_err_d = 1'b1;
        end
        default: begin
          shift_d   = {data_sync_q[1], shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      endcase
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TCW'(TIMEOUT_CYC - 1)) begin
        to_cnt_d    = '0;
        bit_cnt_d   = 4'd0;
        frame_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    if (frame_err_d) begin
      state_d = ST_IDLE;
    end else if (byte_valid_q) begin
      case (state_q)
        ST_IDLE: begin
          if (shift_q == 8'hE0)      state_d = ST_EXT;
          else if (shift_q == 8'hF0) state_d = ST_BRK;
          else                       make_op = map_normal(shift_q);
        end
        ST_EXT: begin
          if (shift_q == 8'hF0) state_d = ST_EXT_BRK;
          else begin
            make_op = map_ext(shift_q);
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

`ifdef REPEAT_FILTER_EN
    // Held flags stay set across frame errors; only a break or reset releases a key.
    brk_op = (state_q == ST_EXT_BRK) ? map_ext(shift_q) : map_normal(shift_q);
    if (byte_valid_q && !frame_err_d && (state_q == ST_BRK || state_q == ST_EXT_BRK))
      held_d[brk_op] = 1'b0;
    if (make_op != 4'd0 && !held_q[make_op]) begin
      usr_op_d        = make_op;
      held_d[make_op] = 1'b1;
    end
`else
    usr_op_d = make_op;
`endif
    op_valid_d = (usr_op_d != 4'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q   <= 2'b11;
      data_sync_q  <= 2'b11;
      filt_clk_q   <= 1'b1;
      filt_cnt_q   <= '0;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'd0;
      parity_q     <= 1'b0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      usr_op_q     <= 4'd0;
      op_valid_q   <= 1'b0;
      state_q      <= ST_IDLE;
`ifdef REPEAT_FILTER_EN
      held_q       <= '0;
`endif
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      filt_clk_q   <= filt_clk_d;
      filt_cnt_q   <= filt_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      usr_op_q     <= usr_op_d;
      op_valid_q   <= op_valid_d;
      state_q      <= state_d;
`ifdef REPEAT_FILTER_EN
      held_q       <= held_d;
`endif
    end
  end

  assign ps2.usr_op    = usr_op_q;
  assign ps2.op_valid  = op_valid_q;
  assign ps2.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios plus random frames checked against a
// byte-level model of prefix tracking, key mapping and (optionally) repeat filtering.
module tb_ps2_key_decoder;
  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 2000;
  localparam int HALF        = 20;
  localparam int LAT         = FILTER_LEN + 3;

  logic clk = 1'b0;
  logic rst;
  ps2_key_decoder_if bus();

  ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .ps2 (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int op_pulses, err_pulses, valid_mismatch = 0, since_stop = -1, op_at_lat;
  int norm_map[256];
  int ext_map[256];
  bit m_ext, m_brk;
  bit held[16];

  task automatic checkOutput(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // One clock step; outputs are sampled on the falling edge, away from the DUT's active edge.
  task automatic tick();
    @(negedge clk);
    if (bus.op_valid) op_pulses++;
    if (bus.frame_err) err_pulses++;
    if (bus.op_valid != (bus.usr_op != 4'd0)) valid_mismatch++;
    if (since_stop >= 0) begin
      since_stop++;
      if (since_stop == LAT) op_at_lat = int'(bus.usr_op);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = bits[i];
      ticks(HALF);
      bus.ps2_clk = 1'b0;
      if (i == 10) since_stop = 0;
      ticks(HALF);
      bus.ps2_clk = 1'b1;
    end
    ticks(HALF);
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = (~^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic model_reset();
    m_ext = 0;
    m_brk = 0;
    for (int i = 0; i < 16; i++) held[i] = 0;
  endtask

  task automatic model_step(input logic [7:0] b, input bit ok, output int exp_op);
    int code;
    exp_op = 0;
    code   = m_ext ? ext_map[b] : norm_map[b];
    if (!ok) begin
      m_ext = 0;
      m_brk = 0;
    end else if (m_brk) begin
`ifdef REPEAT_FILTER_EN
      held[code] = 0;
`endif
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0 && !m_ext) begin
      m_ext = 1;
    end else begin
      m_ext = 0;
`ifdef REPEAT_FILTER_EN
      if (code != 0 && held[code]) code = 0;
      else if (code != 0) held[code] = 1;
`endif
      exp_op = code;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                               input string tag, output int got_ops);
    int exp_op;
    op_pulses  = 0;
    err_pulses = 0;
    op_at_lat  = -1;
    send_bits(frame_bits(b, bad_par, bad_stop), 11);
    since_stop = -1;
    model_step(b, !(bad_par || bad_stop), exp_op);
    checkOutput({tag, "_op_at_latency"}, op_at_lat, exp_op);
    checkOutput({tag, "_op_pulses"}, op_pulses, (exp_op != 0) ? 1 : 0);
    checkOutput({tag, "_frame_err"}, err_pulses, (bad_par || bad_stop) ? 1 : 0);
    got_ops = op_pulses;
  endtask

  initial begin
    logic [7:0] codes[26] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h5A, 8'h31, 8'h55, 8'h4E,
                              8'h21, 8'h2D, 8'h3A, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hE0,
                              8'hF0, 8'hF0, 8'hAA, 8'hFA, 8'hFE, 8'hE1, 8'h00, 8'h12};
    int ops, total;

    for (int i = 0; i < 256; i++) begin
      norm_map[i] = 0;
      ext_map[i]  = 0;
    end
    norm_map[8'h1D] = 1;  norm_map[8'h1B] = 2;  norm_map[8'h1C] = 3;  norm_map[8'h23] = 4;
    norm_map[8'h29] = 5;  norm_map[8'h5A] = 6;  norm_map[8'h31] = 7;  norm_map[8'h55] = 8;
    norm_map[8'h4E] = 9;  norm_map[8'h21] = 10; norm_map[8'h2D] = 11; norm_map[8'h3A] = 12;
    ext_map[8'h75] = 1; ext_map[8'h72] = 2; ext_map[8'h6B] = 3; ext_map[8'h74] = 4; ext_map[8'h5A] = 6;
    model_reset();

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst = 1'b0;
    ticks(5);
    checkOutput("reset_usr_op", int'(bus.usr_op), 0);
    checkOutput("reset_op_valid", int'(bus.op_valid), 0);
    checkOutput("reset_frame_err", int'(bus.frame_err), 0);
    rst = 1'b1;
    ticks(HALF);

    applyStimulus(8'h1D, 0, 0, "w_make", ops);
    applyStimulus(8'hF0, 0, 0, "w_brk_pfx", ops);
    applyStimulus(8'h1D, 0, 0, "w_brk", ops);

    applyStimulus(8'hE0, 0, 0, "ext_pfx", ops);
    applyStimulus(8'h75, 0, 0, "ext_up", ops);
    applyStimulus(8'hE0, 0, 0, "extbrk_pfx1", ops);
    applyStimulus(8'hF0, 0, 0, "extbrk_pfx2", ops);
    applyStimulus(8'h75, 0, 0, "extbrk_up", ops);
    applyStimulus(8'h1C, 0, 0, "idle_after_brk", ops);

    applyStimulus(8'h5A, 1, 0, "bad_parity", ops);
    applyStimulus(8'h29, 0, 0, "after_bad_parity", ops);

    // Partial frame then silence: the decoder must abandon it and recover.
    op_pulses  = 0;
    err_pulses = 0;
    send_bits(frame_bits(8'h1B, 0, 0), 5);
    ticks(TIMEOUT_CYC + 100);
    model_step(8'h00, 0, ops);
    checkOutput("timeout_frame_err", err_pulses, 1);
    checkOutput("timeout_op_pulses", op_pulses, 0);
    applyStimulus(8'h2D, 0, 0, "after_timeout", ops);

    // Short low glitch with data low would look like a start bit if it got through.
    op_pulses  = 0;
    err_pulses = 0;
    bus.ps2_data = 1'b0;
    ticks(HALF);
    bus.ps2_clk = 1'b0;
    ticks(3);
    bus.ps2_clk = 1'b1;
    ticks(HALF);
    checkOutput("glitch_frame_err", err_pulses, 0);
    checkOutput("glitch_op_pulses", op_pulses, 0);
    applyStimulus(8'h55, 0, 0, "after_glitch", ops);

    total = 0;
    applyStimulus(8'h1B, 0, 0, "rep1", ops); total += ops;
    applyStimulus(8'h1B, 0, 0, "rep2", ops); total += ops;
    applyStimulus(8'h1B, 0, 0, "rep3", ops); total += ops;
    applyStimulus(8'hF0, 0, 0, "rep_brk_pfx", ops); total += ops;
    applyStimulus(8'h1B, 0, 0, "rep_brk", ops); total += ops;
    applyStimulus(8'h1B, 0, 0, "rep4", ops); total += ops;
`ifdef REPEAT_FILTER_EN
    checkOutput("repeat_total_pulses", total, 2);
`else
    checkOutput("repeat_total_pulses", total, 4);
`endif

    // Reset in the middle of a frame discards it without any pulse.
    op_pulses  = 0;
    err_pulses = 0;
    applyStimulus(8'hE0, 0, 0, "pre_reset_pfx", ops);
    send_bits(frame_bits(8'h75, 0, 0), 6);
    rst = 1'b0;
    ticks(4);
    rst = 1'b1;
    model_reset();
    op_pulses  = 0;
    err_pulses = 0;
    ticks(TIMEOUT_CYC / 4);
    checkOutput("midreset_op_pulses", op_pulses, 0);
    checkOutput("midreset_frame_err", err_pulses, 0);
    applyStimulus(8'h3A, 0, 0, "after_midreset", ops);

    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      applyStimulus(codes[$urandom_range(0, 25)], r < 10, (r >= 10 && r < 15),
                    $sformatf("rand%0d", i), ops);
    end

    checkOutput("op_valid_matches_usr_op", valid_mismatch, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Receives raw PS/2 keyboard frames (scan code set 2) and translates key presses into single-cycle 4-bit user operation codes.
- Sits directly upstream of the clock-rate controller and game logic.
- Its usr_op output is the design-wide user command bus.
- Handles clock synchronisation, glitch filtering, frame checking, E0/F0 prefix tracking and key-to-op mapping.

Parameters:
- FILTER_LEN, 8, number of consecutive identical synchronised ps2_clk samples required to accept a level change.
- TIMEOUT_CYC, 100000, idle clk cycles mid-frame before the partial frame is abandoned (1 ms at 100 MHz).

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous active-low reset
- ps2_clk  input  1  raw PS/2 clock from keyboard
- ps2_data  input  1  raw PS/2 data from keyboard
- usr_op  output  4  operation code; nonzero for exactly one cycle per accepted key press, 0 otherwise
- op_valid  output  1  high in the same cycle usr_op is nonzero
- frame_err  output  1  one-cycle pulse on a rejected or timed-out frame

Behaviour:
- Reset (rst=0, asynchronous):
  - usr_op=0, op_valid=0, frame_err=0.
  - Bit counter=0, prefix FSM=IDLE, filtered clock=1, timeout counter=0.
- Sync/filter:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - The filtered clock changes only after FILTER_LEN identical consecutive samples.
  - A falling edge of the filtered clock samples synchronised ps2_data.
- Frame (11 bits): start=0, 8 data bits LSB first, odd parity, stop=1.
  - Start bit sampled as 1: ignored, counter stays 0, no error.
  - Parity or stop wrong: frame dropped, frame_err pulses one cycle, prefix FSM returns to IDLE.
  - Byte valid: asserted internally for one cycle in the cycle after the stop-bit edge is detected.
- Timeout:
  - Counter runs while bit counter is nonzero and resets on every accepted falling edge.
  - Reaching TIMEOUT_CYC: counter cleared, frame_err pulses, prefix FSM returns to IDLE.
- Prefix FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
  - IDLE: E0 goes to EXT; F0 goes to BRK; other bytes are decoded as a normal make code.
  - EXT: F0 goes to EXT_BRK; other bytes are decoded as an extended make code, then IDLE.
  - BRK and EXT_BRK: the next byte is a break code; no op is produced; go to IDLE.
- Op map, normal codes:
  - 1D(W)->1 up, 1B(S)->2 down, 1C(A)->3 left, 23(D)->4 right.
  - 29(Space)->5 toggle cell, 5A(Enter)->6 run/pause, 31(N)->7 single step.
  - 55(=)->8 speed up, 4E(-)->9 speed down.
  - 21(C)->10 clear, 2D(R)->11 random fill, 3A(M)->12 mode toggle.
- Op map, extended codes: 75->1, 72->2, 6B->3, 74->4, 5A (keypad Enter)->6.
- Any other make code (including AA, FA, FE, E1): no op, FSM to IDLE.
- Latency: usr_op/op_valid asserted exactly one clk cycle after the internal byte-valid cycle, for one cycle.
- Back-to-back bytes: each produces an independent pulse. There is no queue, because frames are at least 11 PS/2 clocks apart.
- Typematic repeats (repeated make without break): each repeat generates a pulse (see Optional Feature).
- rst asserted mid-frame: partial frame discarded, no pulse after release.

Optional Feature:
- Macro: REPEAT_FILTER_EN.
- Defined:
  - A 13-entry held-key flag vector, one flag per op code.
  - A make sets the flag and emits an op only if the flag was clear.
  - The matching break code (normal or E0-prefixed) clears the flag.
  - Reset clears all flags.
  - A frame error or timeout does not clear flags.
- Undefined: every make code, including typematic repeats, emits an op.

Test Plan:
- Frame 1D, correct parity -> usr_op=1 and op_valid=1 for exactly one cycle, one cycle after byte-valid; frame_err stays 0.
- Sequence E0 75, then E0 F0 75 -> one usr_op=1 pulse; the break sequence produces no pulse and the FSM ends in IDLE.
- Frame 5A with parity bit inverted -> frame_err one-cycle pulse, no op; a following valid 29 -> usr_op=5.
- Send start plus 4 bits, then hold ps2_clk high for TIMEOUT_CYC cycles -> frame_err pulse; the next complete 2D frame -> usr_op=11.
- 3-cycle low glitch on ps2_clk (FILTER_LEN=8) -> no bit sampled; a subsequent valid 55 frame -> usr_op=8.
- 1B, 1B, 1B, F0 1B, 1B:
  - REPEAT_FILTER_EN undefined -> four usr_op=2 pulses.
  - Defined -> exactly two pulses.
